tiq_code_reader: RTL and testbench
==================================

# tiq_code_reader

Digital back end for the TIQ flash ADC comparator bank. Samples the 7-bit thermometer code from the analog core, synchronises it, corrects single-bit bubbles, converts it to a 3-bit binary code, and accumulates 2^AVG_LOG2 samples. Each sum is presented on a valid/ready output port for the pin mux or a serialiser. It sits between the analog quantizer macro and the digital I/O of the tile.

## Interface
- SAMPLE_DIV, 4: clock cycles between sample strobes (≥2).
- AVG_LOG2, 2: log2 of samples per output word (0..4).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- therm  in  7  raw thermometer code; bit0 is the lowest threshold; asynchronous to clk.
- en  in  1  sampling enable; low pauses the divider and accumulator.
- out_data  out  3+AVG_LOG2  sum of AVG_N = 2^AVG_LOG2 codes.
- out_valid  out  1  out_data holds an untransferred result.
- out_ready  in  1  consumer accepts when high with out_valid.
- overflow  out  1  sticky flag: a result was dropped due to backpressure.
- clear_ovf  in  1  clears overflow (synchronous pulse).
- bubble_cnt  out  8  saturating count of strobes where correction changed the code.

## Operation
- Synchroniser: two flops s1←therm, s2←s1, every cycle regardless of en.
- Divider: div counts 0..SAMPLE_DIV-1 while en=1 and holds when en=0. Strobe is combinational, asserted when en=1 and div==SAMPLE_DIV-1; div wraps to 0 on strobe.
- Bubble correction: c[i] = majority(t[i-1], t[i], t[i+1]) with t = s2, t[-1]=1, t[7]=0.
- Code = popcount(c), range 0..7, 3 bits.
- On strobe:
  - acc += code and scnt += 1.
  - If c != s2, bubble_cnt += 1, saturating at 255.
- Last sample (strobe with scnt == AVG_N-1):
  - Result = acc + code.
  - acc and scnt clear to 0.
  - Result is offered to the output register.
- Output register rules:
  - out_valid=0: load result and set out_valid=1.
  - out_valid=1 and out_ready=1 in the same cycle: transfer completes, result loads, out_valid stays 1.
  - out_valid=1 and out_ready=0: result is dropped, out_data is unchanged, overflow←1.
  - Transfer with no new result: out_valid←0. out_data keeps its last value.
- overflow is cleared by clear_ovf. If a set condition and clear_ovf occur in the same cycle, set wins.
- en=0 mid-window: partial acc and scnt are retained and accumulation resumes when en returns. The output handshake continues while en=0.
- Arithmetic: all sums are unsigned. The maximum sum is 7·AVG_N, which fits 3+AVG_LOG2 bits, so there is no wrap.

## Timing
- Reset values: out_data=0, out_valid=0, overflow=0, bubble_cnt=0. Internally s1, s2, div, acc and scnt are all 0.
- Reset mid-window discards the partial accumulation and any pending unaccepted result.
- Input latency: a therm change is visible to the decoder 2 cycles later (in s2).
- First result: with en held high from reset release, out_valid rises on the edge after the AVG_N-th strobe, i.e. AVG_N·SAMPLE_DIV cycles after the first enabled cycle.
- Steady state: one result every AVG_N·SAMPLE_DIV cycles when out_ready=1.
- out_data and out_valid are registered outputs; there is no combinational path from out_ready to any output.
- bubble_cnt and overflow update on the edge of the causing event.

## Test plan
- Reset: drive rst=1 for 2 cycles with therm=7'h7F, en=1. All outputs must read 0 during reset and on the first cycle after release.
- Clean code, SAMPLE_DIV=4, AVG_LOG2=2, therm=7'b0001111, en=1, out_ready=1:
  - out_data=16 with out_valid pulses every 16 cycles.
  - The first pulse occurs 16 cycles after release.
  - bubble_cnt stays 0.
- Extremes: therm=7'h7F must give out_data=28. therm=7'h00 must give out_data=0.
- Bubble: therm=7'b0010111 must correct to 0001111, giving out_data=16. bubble_cnt increments once per strobe and saturates at 255 after 255 strobes.
- Backpressure, out_ready=0 for 40 cycles with therm=7'b0000011:
  - The first result (8) is held.
  - The second result is dropped and overflow=1.
  - Raising out_ready completes one transfer of 8.
  - A clear_ovf pulse returns overflow to 0.
- Reset and pause:
  - Assert rst after 2 strobes; the next result reflects only post-reset samples (4 strobes).
  - Lower en for 10 cycles mid-window; the result timing shifts by exactly 10 cycles.

Source files
------------

// File: rtl/tiq_code_reader_if.sv
// tiq_code_reader_if
//   Valid/ready result port of the TIQ code reader.
//   W          : result width (3 + AVG_LOG2 of the attached reader)
//   out_data   : accumulated code sum, driven by the master
//   out_valid  : out_data holds an untransferred result, driven by the master
//   out_ready  : consumer accepts when high together with out_valid
interface tiq_code_reader_if #(
    parameter int unsigned W = 5
);
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/tiq_code_reader.sv
// tiq_code_reader
//   Back end for the TIQ flash ADC comparator bank. Synchronises the 7-bit
//   thermometer code, removes single-bit bubbles with a 3-input majority,
//   converts to a 3-bit count and sums 2^AVG_LOG2 samples per output word.
// Ports
//   clk, rst   : single clock, synchronous active-high reset
//   therm      : raw thermometer code (bit0 = lowest threshold), async to clk
//   en         : sampling enable; low pauses divider and accumulator
//   out_port   : valid/ready result port (out_data, out_valid, out_ready)
//   overflow   : sticky, a result was dropped because the port was full
//   clear_ovf  : synchronous clear of overflow (a simultaneous drop wins)
//   bubble_cnt : saturating count of strobes where correction altered the code
module tiq_code_reader #(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        therm,
    input  logic              en,
    tiq_code_reader_if.master out_port,
    output logic              overflow,
    input  logic              clear_ovf,
    output logic [7:0]        bubble_cnt
);

    localparam int unsigned OW    = 3 + AVG_LOG2;
    localparam int unsigned AVG_N = 1 << AVG_LOG2;
    localparam int unsigned DW    = $clog2(SAMPLE_DIV);
    localparam int unsigned SW    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(AVG_N - 1);

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_t;

    logic [6:0]    s1;
    logic [6:0]    s2;
    logic [DW-1:0] div;
    logic [OW-1:0] acc;
    logic [SW-1:0] scnt;

    logic [8:0]    tx;
    logic [6:0]    c;
    logic [2:0]    code;
    logic          strobe;
    logic          last;
    logic          result_avail;
    logic [OW-1:0] result;

    out_state_t    state;
    out_state_t    state_next;
    logic          load;
    logic          drop;
    logic [OW-1:0] out_data_q;

    // Decoder: pad s2 with the fixed boundary values (below bit0 reads 1,
    // above bit6 reads 0) so every bit uses the same majority window.
    always_comb begin
        tx = {1'b0, s2, 1'b1};
        c  = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            c[i] = (tx[i] & tx[i+1]) | (tx[i] & tx[i+2]) | (tx[i+1] & tx[i+2]);
        end
        code = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            code = code + {2'b00, c[i]};
        end
    end

    always_comb begin
        strobe       = en && (div == DIV_LAST);
        last         = (scnt == SCNT_LAST);
        result_avail = strobe && last;
        result       = acc + OW'(code);
    end

    // Synchroniser, divider, accumulator and bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            div        <= '0;
            acc        <= '0;
            scnt       <= '0;
            bubble_cnt <= '0;
        end else begin
            s1 <= therm;
            s2 <= s1;
            if (en) begin
                div <= strobe ? '0 : div + 1'b1;
            end
            if (strobe) begin
                if (last) begin
                    acc  <= '0;
                    scnt <= '0;
                end else begin
                    acc  <= result;
                    scnt <= scnt + 1'b1;
                end
                if ((c != s2) && (bubble_cnt != 8'hFF)) begin
                    bubble_cnt <= bubble_cnt + 8'd1;
                end
            end
        end
    end

    // Output holding register: EMPTY/FULL tracks out_valid. A new result
    // replaces the held one only when the held one transfers this cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (result_avail) begin
                    load       = 1'b1;
                    state_next = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_port.out_ready) begin
                    if (result_avail) begin
                        load = 1'b1;
                    end else begin
                        state_next = OUT_EMPTY;
                    end
                end else if (result_avail) begin
                    drop = 1'b1;
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OUT_EMPTY;
            out_data_q <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                out_data_q <= result;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign out_port.out_data  = out_data_q;
    assign out_port.out_valid = (state == OUT_FULL);

endmodule

// File: tb/tb_tiq_code_reader.sv
module tb_tiq_code_reader;

    localparam int unsigned SD = 4;
    localparam int unsigned AL = 2;
    localparam int unsigned AN = 1 << AL;
    localparam int unsigned OW = 3 + AL;

    logic       clk;
    logic       rst;
    logic [6:0] therm;
    logic       en;
    logic       clear_ovf;
    logic       overflow;
    logic [7:0] bubble_cnt;

    tiq_code_reader_if #(.W(OW)) bus ();

    tiq_code_reader #(
        .SAMPLE_DIV(SD),
        .AVG_LOG2  (AL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .therm     (therm),
        .en        (en),
        .out_port  (bus.master),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: samples are counted in enabled cycles, codes are kept
    // in a queue and summed once AN of them have been collected.
    logic [6:0] m_s1, m_s2;
    int         m_phase;
    int         m_codes[$];
    bit         m_valid;
    int         m_data;
    bit         m_ovf;
    int         m_bub;

    function automatic logic [6:0] correct(input logic [6:0] t);
        logic [6:0] r;
        int lo, hi, mid;
        for (int i = 0; i < 7; i++) begin
            lo   = (i == 0) ? 1 : int'(t[i-1]);
            hi   = (i == 6) ? 0 : int'(t[i+1]);
            mid  = int'(t[i]);
            r[i] = ((lo + mid + hi) >= 2);
        end
        return r;
    endfunction

    function automatic int ones(input logic [6:0] v);
        int n = 0;
        for (int i = 0; i < 7; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_step();
        bit strobe;
        bit avail;
        int sum;
        logic [6:0] cc;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_phase = 0; m_codes.delete();
            m_valid = 0; m_data = 0; m_ovf = 0; m_bub = 0;
            return;
        end
        strobe = en && (m_phase == SD - 1);
        avail  = 0;
        sum    = 0;
        if (strobe) begin
            cc = correct(m_s2);
            m_codes.push_back(ones(cc));
            if (cc != m_s2 && m_bub < 255) m_bub++;
            if (m_codes.size() == AN) begin
                foreach (m_codes[k]) sum += m_codes[k];
                m_codes.delete();
                avail = 1;
            end
        end
        if (en) m_phase = (m_phase + 1) % SD;
        if (!m_valid) begin
            if (avail) begin m_valid = 1; m_data = sum; end
        end else if (bus.out_ready) begin
            if (avail) m_data = sum;
            else m_valid = 0;
        end else if (avail) begin
            m_ovf = 1;
            avail = 0;
            sum   = -1;
        end
        if (sum == -1) m_ovf = 1;
        else if (clear_ovf) m_ovf = 0;
        m_s2 = m_s1;
        m_s1 = therm;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("out_valid", int'(bus.out_valid), int'(m_valid));
        check("out_data", int'(bus.out_data), m_data);
        check("overflow", int'(overflow), int'(m_ovf));
        check("bubble_cnt", int'(bubble_cnt), m_bub);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    // Counts cycles until out_valid is seen, bounded.
    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!bus.out_valid && n < max) begin
            cycle();
            n++;
        end
        check("valid_seen", int'(bus.out_valid), 1);
    endtask

    typedef struct {
        logic [6:0] therm;
        int         exp_data;
        int         bub_per_strobe;
    } vec_t;

    vec_t tbl[9];
    int   n;

    initial begin
        tbl[0] = '{7'b0001111, 16, 0};
        tbl[1] = '{7'b1111111, 28, 0};
        tbl[2] = '{7'b0000000,  0, 0};
        tbl[3] = '{7'b0010111, 16, 1};
        tbl[4] = '{7'b0000011,  8, 0};
        tbl[5] = '{7'b0111111, 24, 0};
        tbl[6] = '{7'b0000100,  0, 1};
        tbl[7] = '{7'b1111110, 28, 1};
        tbl[8] = '{7'b0000001,  4, 0};

        rst = 1'b1; therm = 7'h7F; en = 1'b1; clear_ovf = 1'b0;
        bus.out_ready = 1'b1;

        // Reset behaviour
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("rst_valid", int'(bus.out_valid), 0);
            check("rst_data", int'(bus.out_data), 0);
            check("rst_ovf", int'(overflow), 0);
            check("rst_bub", int'(bubble_cnt), 0);
        end
        rst = 1'b0;
        cycle();
        check("post_rst_valid", int'(bus.out_valid), 0);
        check("post_rst_data", int'(bus.out_data), 0);
        check("post_rst_ovf", int'(overflow), 0);
        check("post_rst_bub", int'(bubble_cnt), 0);

        // Table of static codes: first-result latency, value, period, bubbles
        foreach (tbl[i]) begin
            therm = tbl[i].therm;
            en = 1'b1;
            bus.out_ready = 1'b1;
            do_reset(2);
            wait_valid(40, n);
            check("first_latency", n, AN * SD);
            check("tbl_data", int'(bus.out_data), tbl[i].exp_data);
            check("tbl_bub", int'(bubble_cnt), AN * tbl[i].bub_per_strobe);
            cycle();
            check("pulse_low", int'(bus.out_valid), 0);
            wait_valid(40, n);
            check("period", n + 1, AN * SD);
            check("tbl_data2", int'(bus.out_data), tbl[i].exp_data);
        end

        // Bubble counter saturation
        therm = 7'b0010111;
        do_reset(2);
        repeat (270 * SD) cycle();
        check("bub_sat", int'(bubble_cnt), 255);

        // Backpressure: hold first, drop second, transfer, clear
        therm = 7'b0000011;
        bus.out_ready = 1'b0;
        do_reset(2);
        repeat (40) cycle();
        check("bp_valid", int'(bus.out_valid), 1);
        check("bp_data", int'(bus.out_data), 8);
        check("bp_ovf", int'(overflow), 1);
        bus.out_ready = 1'b1;
        cycle();
        check("bp_xfer_valid", int'(bus.out_valid), 0);
        check("bp_xfer_data", int'(bus.out_data), 8);
        check("bp_ovf_sticky", int'(overflow), 1);
        clear_ovf = 1'b1;
        cycle();
        clear_ovf = 1'b0;
        check("bp_ovf_clr", int'(overflow), 0);

        // Reset after two strobes discards partial sum
        therm = 7'h7F;
        do_reset(2);
        repeat (2 * SD) cycle();
        therm = 7'b0000011;
        do_reset(1);
        wait_valid(40, n);
        check("rst_mid_latency", n, AN * SD);
        check("rst_mid_data", int'(bus.out_data), 8);

        // Pause mid-window shifts timing by the pause length
        therm = 7'b0001111;
        do_reset(2);
        repeat (6) cycle();
        en = 1'b0;
        repeat (10) cycle();
        en = 1'b1;
        wait_valid(40, n);
        check("pause_latency", 6 + 10 + n, AN * SD + 10);
        check("pause_data", int'(bus.out_data), 16);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            therm         = 7'($urandom);
            en            = ($urandom % 8) != 0;
            bus.out_ready = ($urandom % 3) != 0;
            clear_ovf     = ($urandom % 16) == 0;
            rst           = ($urandom % 600) == 0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
